// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, flush squash and NOP bubble insertion on the outputs.
module pipe_stage_reg #(
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DATA_W   = 128,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000020,
  parameter bit                SKID     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              r_mainValid;
  logic [INST_W-1:0] r_mainInst;
  logic [DATA_W-1:0] r_mainData;
  logic              r_skidValid;
  logic [INST_W-1:0] r_skidInst;
  logic [DATA_W-1:0] r_skidData;
  logic              r_inReady;
  logic [1:0]        r_occ;

  logic              w_inReady;
  logic              w_accept;
  logic              w_retire;
  logic              w_mainValidNxt;
  logic [INST_W-1:0] w_mainInstNxt;
  logic [DATA_W-1:0] w_mainDataNxt;
  logic              w_skidValidNxt;
  logic [INST_W-1:0] w_skidInstNxt;
  logic [DATA_W-1:0] w_skidDataNxt;
  logic [1:0]        w_occNxt;

  // The stored ready flag is reset to 1, so it is masked while rst is held.
  always_comb begin
    if (SKID) begin
      w_inReady = r_inReady && !rst;
    end else begin
      w_inReady = (!r_mainValid || out_ready) && !rst;
    end
  end

  assign w_accept = in_valid && w_inReady;
  assign w_retire = r_mainValid && out_ready;

  // Empty slots are always loaded with the bubble so the outputs need no muxing.
  always_comb begin
    w_mainValidNxt = r_mainValid;
    w_mainInstNxt  = r_mainInst;
    w_mainDataNxt  = r_mainData;
    w_skidValidNxt = r_skidValid;
    w_skidInstNxt  = r_skidInst;
    w_skidDataNxt  = r_skidData;

    if (w_retire || !r_mainValid) begin
      if (SKID && r_skidValid) begin
        w_mainValidNxt = 1'b1;
        w_mainInstNxt  = r_skidInst;
        w_mainDataNxt  = r_skidData;
        w_skidValidNxt = 1'b0;
        w_skidInstNxt  = NOP_INST;
        w_skidDataNxt  = '0;
      end else if (w_accept) begin
        w_mainValidNxt = 1'b1;
        w_mainInstNxt  = in_inst;
        w_mainDataNxt  = in_data;
      end else begin
        w_mainValidNxt = 1'b0;
        w_mainInstNxt  = NOP_INST;
        w_mainDataNxt  = '0;
      end
    end else if (SKID && w_accept) begin
      w_skidValidNxt = 1'b1;
      w_skidInstNxt  = in_inst;
      w_skidDataNxt  = in_data;
    end

    if (flush) begin
      w_mainValidNxt = 1'b0;
      w_mainInstNxt  = NOP_INST;
      w_mainDataNxt  = '0;
      w_skidValidNxt = 1'b0;
      w_skidInstNxt  = NOP_INST;
      w_skidDataNxt  = '0;
    end

    w_occNxt = {1'b0, w_mainValidNxt} + {1'b0, w_skidValidNxt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mainValid <= 1'b0;
      r_mainInst  <= NOP_INST;
      r_mainData  <= '0;
      r_skidValid <= 1'b0;
      r_skidInst  <= NOP_INST;
      r_skidData  <= '0;
      r_inReady   <= 1'b1;
      r_occ       <= 2'd0;
    end else begin
      r_mainValid <= w_mainValidNxt;
      r_mainInst  <= w_mainInstNxt;
      r_mainData  <= w_mainDataNxt;
      r_skidValid <= w_skidValidNxt;
      r_skidInst  <= w_skidInstNxt;
      r_skidData  <= w_skidDataNxt;
      r_inReady   <= !w_skidValidNxt;
      r_occ       <= w_occNxt;
    end
  end

  assign in_ready  = w_inReady;
  assign out_valid = r_mainValid;
  assign out_inst  = r_mainInst;
  assign out_data  = r_mainData;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share stimulus
// and are compared against FIFO-queue reference models and a directed table.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h00000020;

  typedef struct {
    logic [31:0]  inst;
    logic [127:0] data;
  } entry_t;

  typedef struct {
    bit          rst;
    bit          flush;
    bit          inValid;
    logic [31:0] inst;
    bit          outReady;
    bit          expInReady;
    bit          expValid;
    logic [31:0] expInst;
    logic [1:0]  expOcc;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         inValid;
  logic         outReady;
  logic [31:0]  inInst;
  logic [127:0] inData;

  logic         inReady1, outValid1;
  logic [31:0]  outInst1;
  logic [127:0] outData1;
  logic [1:0]   occ1;
  logic         inReady0, outValid0;
  logic [31:0]  outInst0;
  logic [127:0] outData0;
  logic [1:0]   occ0;

  entry_t q1[$];
  entry_t q0[$];
  vec_t   vecs[$];

  int  errors = 0;
  int  checks = 0;
  bit  preReady1, preReady0;

  pipe_stage_reg #(.INST_W(32), .DATA_W(128), .NOP_INST(32'h00000020), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady1),
    .in_inst(inInst), .in_data(inData), .flush(flush),
    .out_valid(outValid1), .out_ready(outReady), .out_inst(outInst1),
    .out_data(outData1), .occupancy(occ1)
  );

  pipe_stage_reg #(.INST_W(32), .DATA_W(128), .NOP_INST(32'h00000020), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady0),
    .in_inst(inInst), .in_data(inData), .flush(flush),
    .out_valid(outValid0), .out_ready(outReady), .out_inst(outInst0),
    .out_data(outData0), .occupancy(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Post-edge comparison of both instances against their queue models.
  task automatic checkOutput();
    check("skid1.out_valid", {127'd0, outValid1}, {127'd0, q1.size() > 0});
    check("skid1.out_inst", {96'd0, outInst1}, {96'd0, (q1.size() > 0) ? q1[0].inst : NOP});
    check("skid1.out_data", outData1, (q1.size() > 0) ? q1[0].data : 128'd0);
    check("skid1.occupancy", {126'd0, occ1}, 128'(q1.size()));
    check("skid0.out_valid", {127'd0, outValid0}, {127'd0, q0.size() > 0});
    check("skid0.out_inst", {96'd0, outInst0}, {96'd0, (q0.size() > 0) ? q0[0].inst : NOP});
    check("skid0.out_data", outData0, (q0.size() > 0) ? q0[0].data : 128'd0);
    check("skid0.occupancy", {126'd0, occ0}, 128'(q0.size()));
  endtask

  // Drive one cycle of inputs at the falling edge, check ready, clock, check outputs.
  task automatic applyStimulus(input bit r, input bit f, input bit v, input logic [31:0] inst,
                               input logic [127:0] data, input bit ordy);
    bit m1Ready, m0Ready, ret;
    entry_t e;
    rst = r; flush = f; inValid = v; inInst = inst; inData = data; outReady = ordy;
    #1;
    m1Ready = !r && (q1.size() < 2);
    m0Ready = !r && ((q0.size() == 0) || ordy);
    preReady1 = inReady1;
    preReady0 = inReady0;
    check("skid1.in_ready", {127'd0, inReady1}, {127'd0, m1Ready});
    check("skid0.in_ready", {127'd0, inReady0}, {127'd0, m0Ready});
    @(posedge clk);
    e.inst = inst;
    e.data = data;
    if (r || f) begin
      q1.delete();
      q0.delete();
    end else begin
      ret = (q1.size() > 0) && ordy;
      if (ret) void'(q1.pop_front());
      if (v && m1Ready) q1.push_back(e);
      ret = (q0.size() > 0) && ordy;
      if (ret) void'(q0.pop_front());
      if (v && m0Ready) q0.push_back(e);
    end
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    logic [31:0]  ri;
    logic [127:0] rd;
    bit           rr, rf, rv, ro;

    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    inInst = 'x; inData = 'x;

    // rst, flush, inValid, inst, outReady | inReady(pre-edge), valid, inst, occ (post-edge)
    vecs.push_back('{1, 0, 0, 32'h0,        1, 0, 0, NOP,          2'd0});
    vecs.push_back('{1, 0, 0, 32'h0,        1, 0, 0, NOP,          2'd0});
    vecs.push_back('{0, 0, 0, 32'h0,        1, 1, 0, NOP,          2'd0});
    vecs.push_back('{0, 0, 1, 32'h8C010004, 1, 1, 1, 32'h8C010004, 2'd1});
    vecs.push_back('{0, 0, 1, 32'h00221820, 1, 1, 1, 32'h00221820, 2'd1});
    vecs.push_back('{0, 0, 1, 32'hAC030008, 1, 1, 1, 32'hAC030008, 2'd1});
    vecs.push_back('{0, 0, 0, 32'h0,        1, 1, 0, NOP,          2'd0});
    vecs.push_back('{0, 0, 1, 32'hA0000001, 1, 1, 1, 32'hA0000001, 2'd1});
    vecs.push_back('{0, 0, 1, 32'hB0000002, 0, 1, 1, 32'hA0000001, 2'd2});
    vecs.push_back('{0, 0, 1, 32'hC0000003, 0, 0, 1, 32'hA0000001, 2'd2});
    vecs.push_back('{0, 0, 1, 32'hC0000003, 1, 0, 1, 32'hB0000002, 2'd1});
    vecs.push_back('{0, 0, 1, 32'hC0000003, 1, 1, 1, 32'hC0000003, 2'd1});
    vecs.push_back('{0, 0, 1, 32'hD0000004, 1, 1, 1, 32'hD0000004, 2'd1});
    vecs.push_back('{0, 0, 0, 32'h0,        1, 1, 0, NOP,          2'd0});
    vecs.push_back('{0, 0, 1, 32'hE0000001, 0, 1, 1, 32'hE0000001, 2'd1});
    vecs.push_back('{0, 0, 1, 32'hE0000002, 0, 1, 1, 32'hE0000001, 2'd2});
    vecs.push_back('{0, 1, 1, 32'h12345678, 0, 0, 0, NOP,          2'd0});
    vecs.push_back('{0, 0, 0, 32'h0,        1, 1, 0, NOP,          2'd0});
    vecs.push_back('{0, 0, 1, 32'hF0000001, 0, 1, 1, 32'hF0000001, 2'd1});
    vecs.push_back('{0, 1, 1, 32'h12345678, 0, 1, 0, NOP,          2'd0});
    vecs.push_back('{0, 0, 0, 32'h0,        1, 1, 0, NOP,          2'd0});
    vecs.push_back('{0, 0, 1, 32'h90000001, 0, 1, 1, 32'h90000001, 2'd1});
    vecs.push_back('{0, 0, 1, 32'h90000002, 0, 1, 1, 32'h90000001, 2'd2});
    vecs.push_back('{1, 0, 1, 32'h90000003, 0, 0, 0, NOP,          2'd0});
    vecs.push_back('{0, 0, 0, 32'h0,        1, 1, 0, NOP,          2'd0});
    vecs.push_back('{0, 0, 0, 32'h0,        1, 1, 0, NOP,          2'd0});

    @(negedge clk);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].inValid,
                    vecs[i].inValid ? vecs[i].inst : 32'hxxxxxxxx,
                    vecs[i].inValid ? {4{vecs[i].inst}} : {128{1'bx}},
                    vecs[i].outReady);
      check($sformatf("vec%0d.in_ready", i), {127'd0, preReady1}, {127'd0, vecs[i].expInReady});
      check($sformatf("vec%0d.out_valid", i), {127'd0, outValid1}, {127'd0, vecs[i].expValid});
      check($sformatf("vec%0d.out_inst", i), {96'd0, outInst1}, {96'd0, vecs[i].expInst});
      check($sformatf("vec%0d.out_data", i), outData1,
            vecs[i].expValid ? {4{vecs[i].expInst}} : 128'd0);
      check($sformatf("vec%0d.occupancy", i), {126'd0, occ1}, {126'd0, vecs[i].expOcc});
    end

    // Single-entry instance: ready follows out_ready in the same cycle.
    applyStimulus(0, 0, 1, 32'h11110001, {4{32'h11110001}}, 1);
    check("skid0.hold.valid", {127'd0, outValid0}, 128'd1);
    check("skid0.hold.inst", {96'd0, outInst0}, {96'd0, 32'h11110001});
    applyStimulus(0, 0, 0, 32'hxxxxxxxx, {128{1'bx}}, 0);
    check("skid0.stall.in_ready", {127'd0, preReady0}, 128'd0);
    check("skid0.stall.inst", {96'd0, outInst0}, {96'd0, 32'h11110001});
    applyStimulus(0, 0, 1, 32'h11110002, {4{32'h11110002}}, 1);
    check("skid0.swap.in_ready", {127'd0, preReady0}, 128'd1);
    check("skid0.swap.inst", {96'd0, outInst0}, {96'd0, 32'h11110002});
    check("skid0.swap.occupancy", {126'd0, occ0}, 128'd1);

    for (int n = 0; n < 600; n++) begin
      rr = ($urandom_range(99) < 2);
      rf = ($urandom_range(99) < 5);
      rv = ($urandom_range(99) < 70);
      ro = ($urandom_range(99) < 60);
      ri = $urandom;
      rd = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(rr, rf, rv, rv ? ri : 32'hxxxxxxxx, rv ? rd : {128{1'bx}}, ro);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
